multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Iterative signed multiply/divide unit with its own sequencing FSM.
- Serves the single-cycle processor's ALUop 00110 (mul) and 00111 (div).
- Asserts a stall so the PC and register-file write are held while an operation is in flight.
- Returns a result, an exception flag and a one-cycle ready pulse, which the processor writes to Rd, or to r30 on exception.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ctrl_MULT  in  1  start pulse for multiply, sampled on a clock edge.
- ctrl_DIV  in  1  start pulse for divide, sampled on a clock edge.
- data_operandA  in  WIDTH  multiplicand/dividend, signed; sampled with the start pulse.
- data_operandB  in  WIDTH  multiplier/divisor, signed; sampled with the start pulse.
- data_result  out  WIDTH  product low word / quotient; registered.
- data_exception  out  1  overflow or divide-by-zero; registered.
- data_resultRDY  out  1  one-cycle pulse: result and exception are valid.
- stall  out  1  high while state is MUL or DIV; processor holds PC and write enable.

Behaviour:
- Reset: asynchronous and active-low. While reset=0, the unit is forced as follows:
  - state=IDLE and count=0;
  - data_result=0, data_exception=0, data_resultRDY=0, stall=0.
  - Reset mid-operation aborts the operation; no resultRDY is produced.
- States:
  - IDLE.
  - MUL: one shift-add step per edge.
  - DIV: one restoring shift-subtract step per edge.
  - DONE: resultRDY=1 for exactly one cycle; the next edge returns to IDLE.
- Start, from IDLE only:
  - ctrl_MULT=1 at edge E0 → MUL, count=0.
  - ctrl_DIV=1 at edge E0 → DIV, count=0.
  - Both high → MUL wins; DIV is ignored.
  - Start pulses in MUL, DIV or DONE are ignored and not queued.
- Operand capture at E0:
  - Store |A| and |B| (two's-complement negate when the sign bit is set).
  - Store sign flag = A[WIDTH-1]^B[WIDTH-1].
  - Division also stores the dividend sign (remainder is discarded, so only the quotient sign matters).
- Iteration and latency:
  - Count increments each edge in MUL/DIV.
  - The edge taken with count==WIDTH-1 moves to DONE.
  - resultRDY is therefore high during the cycle after edge E_WIDTH, i.e. WIDTH cycles after the start edge.
- MUL arithmetic:
  - 2*WIDTH-bit unsigned accumulator; negated at completion if the sign flag is set.
  - data_result = low WIDTH bits.
  - exception=1 when the 2*WIDTH signed product ≠ sign-extension of its low WIDTH bits.
  - Example: -2^31 * -1 → exception=1, result=0x80000000.
- DIV arithmetic:
  - Unsigned restoring division; quotient negated if the sign flag is set; truncates toward zero.
  - Divisor==0 at E0 → go straight to DONE: resultRDY one cycle after E0, result=0, exception=1.
  - -2^31 / -1 → result=0x80000000, exception=1.
- Output hold: data_result/data_exception update only on the edge entering DONE, and hold until the next DONE.
- Stall:
  - stall=1 exactly while the state is MUL or DIV; 0 in IDLE and DONE.
  - It is registered, so in the start cycle itself the processor must gate on ctrl_MULT|ctrl_DIV.

Optional Feature:
- Macro MULTDIV_EARLY_OUT_EN.
- When defined, MUL skips to DONE on the edge after the remaining unshifted multiplier bits are all zero. Latency = position of the highest set bit of |B| plus 2 cycles; |B|==0 gives resultRDY 1 cycle after E0 with result 0.
- DIV latency is unchanged.
- Undefined: MUL latency is always WIDTH cycles.
- Results and exception are identical either way.

Decomposition:
- Package multdiv_pkg holds:
  - state encoding IDLE/MUL/DIV/DONE;
  - ALUOP_MUL=5'b00110 and ALUOP_DIV=5'b00111;
  - default WIDTH.
- One natural sub-module, multdiv_datapath: accumulator/remainder/quotient registers plus the adder/subtractor, driven by the step/load/finish strobes from multdiv_ctrl's FSM.
- Sign handling and the FSM stay in multdiv_ctrl.

Test Plan:
- MULT, A=7, B=-6 → stall high WIDTH cycles; resultRDY at cycle 32; result=0xFFFFFFD6 (-42), exception=0.
- DIV, A=-100, B=7 → resultRDY at cycle 32; result=0xFFFFFFF2 (-14), exception=0.
- DIV, A=5, B=0 → resultRDY one cycle after start, result=0, exception=1, stall never high.
- MULT, A=65536, B=65536 → result=0, exception=1; then MULT 3*4 → result=12, exception cleared.
- ctrl_MULT and ctrl_DIV both high, A=6, B=3 → result=18; a ctrl_DIV pulse at cycle 10 mid-operation is ignored; exactly one resultRDY.
- Reset low at cycle 15 of a DIV → all outputs 0 immediately; no resultRDY; a new MULT 2*2 after release gives 4.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package multdiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/multdiv_if.sv
// Processor-facing handshake of the multiply/divide unit: start strobes, operands, result and stall.
interface multdiv_if import multdiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             stall;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, stall
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, stall
  );

endinterface

// File: rtl/multdiv_datapath.sv
// Unsigned shift-add multiplier and restoring divider registers, stepped by the multdiv_ctrl FSM.
// MULTDIV_EARLY_OUT_EN: report when the remaining multiplier bits are exhausted so MUL can stop early.
module multdiv_datapath import multdiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clock,
  input  logic               load_i,
  input  logic               mul_step_i,
  input  logic               div_step_i,
  input  logic [WIDTH-1:0]   a_mag_i,
  input  logic [WIDTH-1:0]   b_mag_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0]   quot_o,
  output logic               mul_exhaust_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   divs_q, divs_d;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    divs_d   = divs_q;
    // Dividend MSB enters the partial remainder as the quotient register shifts left.
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    rem_ge   = rem_sh >= {1'b0, divs_q};
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_mag_i};
      mplier_d = b_mag_i;
      rem_d    = '0;
      quo_d    = a_mag_i;
      divs_d   = b_mag_i;
    end else begin
      if (mul_step_i) begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
      if (div_step_i) begin
        if (rem_ge) begin
          rem_d = WIDTH'(rem_sh - {1'b0, divs_q});
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    rem_q    <= rem_d;
    quo_q    <= quo_d;
    divs_q   <= divs_d;
  end

  // The controller latches these on the finishing edge, so they include that edge's step.
  assign prod_o = acc_d;
  assign quot_o = quo_d;

`ifdef MULTDIV_EARLY_OUT_EN
  assign mul_exhaust_o = (mplier_q == '0);
`else
  assign mul_exhaust_o = 1'b0;
`endif

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing FSM, sign handling and result registers of the iterative signed multiply/divide unit.
// MULTDIV_EARLY_OUT_EN (in multdiv_datapath) lets MUL finish once the multiplier bits run out.
module multdiv_ctrl import multdiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic      clock,
  input logic      reset,
  multdiv_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [WIDTH-1:0]          result_q, result_d;
  logic                      exc_q, exc_d;
  logic                      sign_q, dvd_neg_q;
  logic                      load, mul_step, div_step;
  logic [WIDTH-1:0]          a_mag, b_mag;
  logic [2*WIDTH-1:0]        prod;
  logic [WIDTH-1:0]          quot;
  logic                      mul_exhaust;
  logic signed [2*WIDTH-1:0] prod_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Product overflows when the high word is not a sign extension of the low word.
  function automatic logic mul_ovf(input logic signed [2*WIDTH-1:0] p);
    return p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
  endfunction

  assign a_mag  = magnitude(bus.data_operandA);
  assign b_mag  = magnitude(bus.data_operandB);
  assign prod_s = sign_q ? -$signed(prod) : $signed(prod);

  multdiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clock         (clock),
    .load_i        (load),
    .mul_step_i    (mul_step),
    .div_step_i    (div_step),
    .a_mag_i       (a_mag),
    .b_mag_i       (b_mag),
    .prod_o        (prod),
    .quot_o        (quot),
    .mul_exhaust_o (mul_exhaust)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;
    exc_d    = exc_q;
    load     = 1'b0;
    mul_step = 1'b0;
    div_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ctrl_MULT) begin
          state_d = MUL;
          count_d = '0;
          load    = 1'b1;
        end else if (bus.ctrl_DIV) begin
          // A zero divisor never enters the iteration, so stall stays low.
          if (bus.data_operandB == '0) begin
            state_d  = DONE;
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            state_d = DIV;
            count_d = '0;
            load    = 1'b1;
          end
        end
      end
      MUL: begin
        mul_step = 1'b1;
        count_d  = count_q + CNT_W'(1);
        if (count_q == LAST || mul_exhaust) begin
          state_d  = DONE;
          result_d = prod_s[WIDTH-1:0];
          exc_d    = mul_ovf(prod_s);
        end
      end
      DIV: begin
        div_step = 1'b1;
        count_d  = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          state_d  = DONE;
          result_d = apply_sign(quot, sign_q);
          // Only a negative dividend can reach 2^(WIDTH-1) in magnitude with a positive quotient.
          exc_d    = dvd_neg_q & ~sign_q & quot[WIDTH-1];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (load) begin
      sign_q    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      dvd_neg_q <= bus.data_operandA[WIDTH-1];
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.stall          = (state_q == MUL) || (state_q == DIV);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: vector table plus hand-written reset/overlap sequences, scoreboard-checked.
module tb_multdiv_ctrl;

  localparam int W = 32;

  typedef struct {
    int          op;    // 0 = mul, 1 = div, 2 = both strobes
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   rdy_cnt;
  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[16];

  multdiv_if #(.WIDTH(W)) bus ();

  multdiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    if (op != 1) begin
      logic signed [63:0] p;
      p = 64'($signed(a)) * 64'($signed(b));
      r = p[31:0];
      e = (p[63:32] != {32{p[31]}});
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      r = 32'h80000000;
      e = 1'b1;
    end else begin
      r = 32'($signed(a) / $signed(b));
      e = 1'b0;
    end
  endfunction

  function automatic int exp_lat(input int op, input logic [31:0] b);
    if (op == 1 && b == 32'd0) return 0;
`ifdef MULTDIV_EARLY_OUT_EN
    if (op != 1) begin
      logic [31:0] m;
      int hb;
      m  = b[31] ? -b : b;
      if (m == 32'd0) return 1;
      hb = 0;
      for (int i = 0; i < 32; i++) if (m[i]) hb = i;
      return (hb + 2 > W) ? W : hb + 2;
    end
`endif
    return W;
  endfunction

  // Scoreboard: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && bus.data_resultRDY) begin
      rdy_cnt++;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rdy: got result 0x%08h with nothing outstanding", bus.data_result);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_result", bus.data_result, mon_e.res);
        check("sb_exception", 32'(bus.data_exception), 32'(mon_e.exc));
      end
    end
  end

  // Called at a falling edge with the unit idle; returns at a falling edge with the unit idle.
  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eres, input logic eexc, input string name);
    int   edges;
    int   stalls;
    int   lat;
    bit   seen;
    exp_t e;
    lat = exp_lat(op, b);
    bus.ctrl_MULT     = (op != 1);
    bus.ctrl_DIV      = (op != 0);
    bus.data_operandA = a;
    bus.data_operandB = b;
    e.res = eres;
    e.exc = eexc;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    edges  = 0;
    stalls = 0;
    seen   = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (bus.data_resultRDY) seen = 1'b1;
      else begin
        if (bus.stall) stalls++;
        @(posedge clock);
        edges++;
      end
    end
    check({name, "_rdy_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(edges), 32'(lat));
    check({name, "_stall_cycles"}, 32'(stalls), 32'(lat));
    @(negedge clock);
    check({name, "_rdy_one_cycle"}, 32'(bus.data_resultRDY), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, rr;
    logic        re;
    int          base;

    n_tests = 0;
    n_fail  = 0;
    rdy_cnt = 0;
    vecs[0]  = '{0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0};
    vecs[1]  = '{1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0};
    vecs[2]  = '{1, 32'd5,        32'd0,        32'd0,        1'b1};
    vecs[3]  = '{0, 32'd65536,    32'd65536,    32'd0,        1'b1};
    vecs[4]  = '{0, 32'd3,        32'd4,        32'd12,       1'b0};
    vecs[5]  = '{0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[6]  = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[7]  = '{1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0};
    vecs[8]  = '{1, 32'd7,        32'd100,      32'd0,        1'b0};
    vecs[9]  = '{0, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[10] = '{1, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[11] = '{0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1,        1'b1};
    vecs[12] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0};
    vecs[13] = '{1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[14] = '{0, 32'd0,        32'd5,        32'd0,        1'b0};
    vecs[15] = '{0, 32'd46341,    32'd46341,    32'h80001219, 1'b1};

    reset             = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    #12;
    check("rst_result", bus.data_result, 32'd0);
    check("rst_exception", 32'(bus.data_exception), 32'd0);
    check("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 16; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, $sformatf("vec%0d", i));

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = 32'($urandom_range(0, 400)) - 32'd200;
      if (i >= 6) rb = $urandom;
      model(i % 2, ra, rb, rr, re);
      do_op(i % 2, ra, rb, rr, re, $sformatf("rnd%0d", i));
    end

    // Both strobes: multiply wins; a divide strobe mid-operation must be dropped.
    base = rdy_cnt;
    bus.ctrl_MULT     = 1'b1;
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'd6;
    bus.data_operandB = 32'd3;
    sb_q.push_back('{32'd18, 1'b0});
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'd100;
    bus.data_operandB = 32'd1;
    @(posedge clock);
    #1;
    bus.ctrl_DIV = 1'b0;
    repeat (70) @(negedge clock);
    check("both_rdy_count", 32'(rdy_cnt - base), 32'd1);
    check("both_result_held", bus.data_result, 32'd18);
    check("both_sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of a divide aborts it with no ready pulse.
    do_op(1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0, "pre_rst");
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'hFFFFFF9C;
    bus.data_operandB = 32'd7;
    sb_q.push_back('{32'hFFFFFFF2, 1'b0});
    @(posedge clock);
    #1;
    bus.ctrl_DIV = 1'b0;
    repeat (14) @(posedge clock);
    #2;
    check("mid_div_stall", 32'(bus.stall), 32'd1);
    reset = 1'b0;
    #1;
    sb_q.delete();
    check("midrst_result", bus.data_result, 32'd0);
    check("midrst_exception", 32'(bus.data_exception), 32'd0);
    check("midrst_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("midrst_stall", 32'(bus.stall), 32'd0);
    base = rdy_cnt;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("midrst_no_rdy", 32'(rdy_cnt - base), 32'd0);
    do_op(0, 32'd2, 32'd2, 32'd4, 1'b0, "post_rst");

    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
